// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg: shared widths, NOP control words and ctrl-bus bit fields   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_DATA_W  = 96;
  localparam int EX_MEM_DATA_W = 69;
  localparam int MEM_WB_DATA_W = 69;
  localparam int STAGE_CTRL_W  = 8;

  // Control bus bit positions
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_ALU_LSB   = 3;
  localparam int CTRL_ALU_W     = 3;
  localparam int CTRL_ALU_SRC   = 6;
  localparam int CTRL_BRANCH    = 7;

  // Bubble words keep every state-writing bit low
  localparam logic [STAGE_CTRL_W-1:0] BUBBLE_IF_ID  = 8'h00;
  localparam logic [STAGE_CTRL_W-1:0] BUBBLE_ID_EX  = 8'h00;
  localparam logic [STAGE_CTRL_W-1:0] BUBBLE_EX_MEM = 8'h00;
  localparam logic [STAGE_CTRL_W-1:0] BUBBLE_MEM_WB = 8'h00;

  function automatic logic ctrl_writes_state(input logic [STAGE_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REG_WRITE] | ctrl[CTRL_MEM_WRITE];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter: up-counter that sticks at its all-ones value            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_skid: valid/ready pipeline register with 2-entry skid,    |
// | synchronous flush and saturating stall counter.  Rev 1.0             |
// +----------------------------------------------------------------------+
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = ID_EX_DATA_W,
  parameter int                 CTRL_W      = STAGE_CTRL_W,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(BUBBLE_ID_EX),
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;

  logic in_fire;
  logic out_fire;

  // in_ready depends only on the skid flop, so out_ready never reaches it
  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : BUBBLE_CTRL;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = '0;
      m_ctrl_d  = BUBBLE_CTRL;
    end else if (s_valid_q) begin
      if (out_fire) begin
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!m_valid_q || out_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end else begin
        // Downstream stalled while main is full: park the entry in skid
        s_valid_d = 1'b1;
        s_data_d  = in_data;
        s_ctrl_d  = in_ctrl;
      end
    end else if (out_fire) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (m_valid_q & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_skid: directed self-checking bench for pipe_stage_skid |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam int             DW  = 96;
  localparam int             CW  = 8;
  localparam logic [CW-1:0]  BUB = 8'h3C;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [15:0]   stall_cnt;

  logic          s2_flush;
  logic          s2_in_valid;
  logic          s2_in_ready;
  logic [DW-1:0] s2_in_data;
  logic [CW-1:0] s2_in_ctrl;
  logic          s2_out_valid;
  logic          s2_out_ready;
  logic [DW-1:0] s2_out_data;
  logic [CW-1:0] s2_out_ctrl;
  logic [3:0]    s2_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .CNT_W(4)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .flush(s2_flush),
    .in_valid(s2_in_valid), .in_ready(s2_in_ready), .in_data(s2_in_data), .in_ctrl(s2_in_ctrl),
    .out_valid(s2_out_valid), .out_ready(s2_out_ready), .out_data(s2_out_data), .out_ctrl(s2_out_ctrl),
    .stall_cnt(s2_stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_ctrl !== BUB) begin failures++; $display("FAIL reset_out_ctrl got=%0h exp=%0h", out_ctrl, BUB); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 8; k++) begin
      in_valid  = 1'b1;
      in_data   = DW'(k);
      in_ctrl   = CW'(k);
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(k)) begin failures++; $display("FAIL stream_data k=%0d got_v=%0h got_d=%0h exp_d=%0h", k, out_valid, out_data, k); end
      checks++; if (out_ctrl !== CW'(k)) begin failures++; $display("FAIL stream_ctrl k=%0d got=%0h exp=%0h", k, out_ctrl, k); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready k=%0d got=%0h exp=1", k, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL stream_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(32'hA);
    in_ctrl   = 8'h11;
    step();
    in_data = DW'(32'hB);
    in_ctrl = 8'h22;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_in_ready_low got=%0h exp=0", in_ready); end
    checks++; if (out_data !== DW'(32'hA)) begin failures++; $display("FAIL skid_hold_a1 got=%0h exp=a", out_data); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL skid_cnt1 got=%0d exp=1", stall_cnt); end
    step();
    step();
    checks++; if (out_data !== DW'(32'hA) || out_ctrl !== 8'h11) begin failures++; $display("FAIL skid_hold_a3 got_d=%0h got_c=%0h exp=a/11", out_data, out_ctrl); end
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL skid_cnt3 got=%0d exp=3", stall_cnt); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== DW'(32'hB) || out_ctrl !== 8'h22) begin failures++; $display("FAIL skid_b_next got_v=%0h got_d=%0h got_c=%0h exp=1/b/22", out_valid, out_data, out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_in_ready_high got=%0h exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_empty got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL skid_cnt_final got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(32'h21);
    in_ctrl   = 8'h81;
    step();
    in_data = DW'(32'h22);
    in_ctrl = 8'h82;
    step();
    in_data = DW'(32'h23);
    in_ctrl = 8'h83;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_ctrl !== BUB) begin failures++; $display("FAIL flush_out_ctrl got=%0h exp=%0h", out_ctrl, BUB); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL flush_out_data got=%0h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0h exp=1", in_ready); end
    checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=5", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_c i=%0d got_v=%0h got_d=%0h exp_v=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_flush_fire();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'(32'h31);
    in_ctrl   = 8'h44;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== DW'(32'h31)) begin failures++; $display("FAIL ff_d_presented got_v=%0h got_d=%0h exp=1/31", out_valid, out_data); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL ff_empty got_v=%0h got_r=%0h exp=0/1", out_valid, in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ff_no_dup got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL ff_stall_cnt got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'hA5;
    in_data   = DW'(32'h41);
    step();
    in_data = DW'(32'h42);
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || stall_cnt !== 16'd6) begin failures++; $display("FAIL rf_full got_r=%0h got_cnt=%0d exp=0/6", in_ready, stall_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rf_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_ctrl !== BUB) begin failures++; $display("FAIL rf_out_ctrl got=%0h exp=%0h", out_ctrl, BUB); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rf_out_data got=%0h exp=0", out_data); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rf_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rf_in_ready got=%0h exp=1", in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rf_no_replay got=%0h exp=0", out_valid); end
  endtask

  task automatic test_saturate();
    s2_out_ready = 1'b0;
    s2_in_valid  = 1'b1;
    s2_in_data   = DW'(32'h55);
    s2_in_ctrl   = 8'h01;
    step();
    s2_in_valid = 1'b0;
    checks++; if (s2_stall_cnt !== 4'd0) begin failures++; $display("FAIL sat_start got=%0d exp=0", s2_stall_cnt); end
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++; if (s2_stall_cnt !== ((i > 15) ? 4'd15 : 4'(i))) begin failures++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, s2_stall_cnt, (i > 15) ? 15 : i); end
    end
    checks++; if (s2_out_valid !== 1'b1 || s2_out_data !== DW'(32'h55)) begin failures++; $display("FAIL sat_entry_held got_v=%0h got_d=%0h exp=1/55", s2_out_valid, s2_out_data); end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_ctrl      = '0;
    out_ready    = 1'b0;
    s2_flush     = 1'b0;
    s2_in_valid  = 1'b0;
    s2_in_data   = '0;
    s2_in_ctrl   = '0;
    s2_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush_full();
    test_flush_fire();
    test_reset_full();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque data bus and one control bus with a valid/ready handshake.
- Uses a 2-entry skid buffer, so back-pressure sustains full throughput.
- Supports a synchronous flush that inserts a bubble with safe control values, and a saturating stall counter for performance debug.

Parameters:
- DATA_W, 96: width of the data bus (e.g. dataone, write data and immediate concatenated).
- CTRL_W, 8: width of the control bus (RegWrite, MemtoReg, MemWrite, ALUControl, ...).
- BUBBLE_CTRL, 0: control value presented when the stage holds no valid entry (NOP: no register or memory write).
- CNT_W, 16: width of the stall counter.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- flush, in, 1: synchronous kill of all held and incoming entries.
- in_valid, in, 1: upstream entry present.
- in_ready, out, 1: stage can accept an entry.
- in_data, in, DATA_W: upstream data.
- in_ctrl, in, CTRL_W: upstream control.
- out_valid, out, 1: downstream entry present.
- out_ready, in, 1: downstream accepts the entry.
- out_data, out, DATA_W: held data.
- out_ctrl, out, CTRL_W: held control, or BUBBLE_CTRL when out_valid=0.
- stall_cnt, out, CNT_W: count of cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- State:
  - main entry M (m_valid, m_data, m_ctrl) drives the outputs;
  - skid entry S (s_valid, s_data, s_ctrl).
- in_ready = ~s_valid. It is a registered state bit, with no combinational path from out_ready.
- out_valid = m_valid; out_data = m_data.
- out_ctrl = m_valid ? m_ctrl : BUBBLE_CTRL.
- Handshake definitions:
  - in_fire = in_valid & in_ready;
  - out_fire = out_valid & out_ready.
- in_data and in_ctrl are sampled only on in_fire. out_data is stable while out_valid=1 and out_ready=0.
- Latency: an entry accepted at edge N is visible at the outputs after edge N; it is presented downstream from cycle N+1.
- Throughput: 1 entry per cycle while out_ready=1.
- Priority per edge: rst > flush > normal update.
- Reset:
  - m_valid, s_valid and stall_cnt go to 0;
  - m_data, s_data, m_ctrl and s_ctrl go to 0;
  - so after reset: out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, in_ready=1.
  - Reset mid-transfer discards all entries; nothing is replayed.
- Flush:
  - m_valid and s_valid go to 0; m_data is cleared to 0; m_ctrl is set to BUBBLE_CTRL.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle still counts as delivered downstream.
  - stall_cnt is unaffected.
  - Next cycle: out_valid=0, in_ready=1.
- Normal update, evaluated in order:
  1. s_valid=1 and out_fire: M <= S, s_valid <= 0.
  2. s_valid=1 and no out_fire: hold everything.
  3. s_valid=0 and in_fire and (m_valid=0 or out_fire): M <= input, m_valid <= 1.
  4. s_valid=0 and in_fire and m_valid=1 and no out_fire: S <= input, s_valid <= 1. This is the skid case; in_ready falls next cycle.
  5. s_valid=0, no in_fire, out_fire: m_valid <= 0.
- Invariants: s_valid=1 implies m_valid=1. No entry is ever duplicated or lost except by flush or reset.
- Ordering: entries leave in exactly their accepted order.
- stall_cnt: increments on each cycle with out_valid & ~out_ready; holds at 2^CNT_W-1.

Decomposition:
- Shared package pipe_pkg holds:
  - the default DATA_W and CTRL_W for each stage;
  - the BUBBLE_CTRL constants per stage (ID/EX NOP control word);
  - the control-field bit-position localparams for the ctrl bus.
- sat_counter (width parameter, inc, rst) is the natural sub-module for stall_cnt.
- Skid logic stays inline.

Test Plan:
- Reset, then in_valid=1 and out_ready=1 streaming data 1..8 -> out_data 1..8 on consecutive cycles starting one cycle after the first accept; in_ready stays 1; stall_cnt=0.
- Accept A, hold out_ready=0, offer B -> B goes to the skid entry, in_ready=0 next cycle, out_data=A held for 3 stall cycles. Then raise out_ready -> A then B back-to-back, in_ready=1 again; stall_cnt=3.
- Flush with both entries full (out_ready=0, in_valid=1 offering C) -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=1; C never appears at the outputs.
- Flush in the same cycle as out_fire of entry D -> D counts as delivered, the stage is empty afterward, and no D duplicate appears.
- Assert rst with both entries full, ctrl=8'hA5 -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, stall_cnt=0.
- CNT_W=4, hold out_ready=0 for 20 cycles with a valid entry -> stall_cnt reads 15 and stays there.
